// File: rtl/load_store_dep_checker_pipelined.sv
`default_nettype none
// ---------------------------------------------------------------------------
// load_store_dep_checker_pipelined: picks youngest overlapping older store for a fired
// load, then forwards/sleeps it; keeps a sleep table and issues one wakeup per cycle. rev 1.0
// ---------------------------------------------------------------------------
module load_store_dep_checker_pipelined #(
    parameter int XLEN          = 32,
    parameter int ROB_TAG_WIDTH = 32,
    parameter int LDQ_SIZE      = 16,
    parameter int STQ_SIZE      = 16,
    localparam int WB   = XLEN / 8,
    localparam int OFFW = $clog2(WB),
    localparam int LQW  = $clog2(LDQ_SIZE),
    localparam int SQW  = $clog2(STQ_SIZE)
) (
    input  logic                                   clk,
    input  logic                                   reset_n,
    input  logic                                   flush,
    input  logic [LDQ_SIZE-1:0][XLEN-1:0]          ldq_address,
    input  logic [LDQ_SIZE-1:0][1:0]               ldq_size,
    input  logic [LDQ_SIZE-1:0][STQ_SIZE-1:0]      ldq_store_mask,
    input  logic [STQ_SIZE-1:0]                    stq_valid,
    input  logic [STQ_SIZE-1:0][XLEN-1:0]          stq_address,
    input  logic [STQ_SIZE-1:0][1:0]               stq_size,
    input  logic [STQ_SIZE-1:0]                    stq_address_valid,
    input  logic [STQ_SIZE-1:0]                    stq_data_valid,
    input  logic [STQ_SIZE-1:0][ROB_TAG_WIDTH-1:0] stq_rob_tag,
    input  logic [SQW-1:0]                         stq_head,
    input  logic                                   load_fired,
    input  logic [LQW-1:0]                         load_fired_ldq_index,
    output logic                                   kill_mem_req,
    output logic                                   forward,
    output logic [SQW-1:0]                         stq_forward_index,
    output logic [OFFW-1:0]                        forward_byte_shift,
    output logic                                   sleep,
    output logic [ROB_TAG_WIDTH-1:0]               sleep_rob_tag,
    output logic [LDQ_SIZE-1:0]                    sleeping,
    output logic                                   wake_valid,
    output logic [LQW-1:0]                         wake_ldq_index
);

    function automatic logic [WB-1:0] byte_mask(input logic [1:0] sz, input logic [OFFW-1:0] off);
        logic [WB-1:0] base;
        for (int b = 0; b < WB; b++) base[b] = (b < (1 << sz));
        return base << off;
    endfunction

    logic [XLEN-1:0]          ld_addr;
    logic [WB-1:0]            ld_mask;
    logic [WB-1:0]            st_mask;
    logic [WB-1:0]            best_mask;
    logic [SQW-1:0]           age;
    logic [SQW-1:0]           best_age;
    logic [SQW-1:0]           best_idx;
    logic                     found;
    logic                     covers;
    logic                     can_fwd;
    logic                     insert;
    logic                     wake_hit;
    logic                     wake_go;
    logic [LQW-1:0]           wake_sel;
    logic [LDQ_SIZE-1:0][SQW-1:0] tbl_idx;
    logic [LDQ_SIZE-1:0]      tbl_commit;

    // Youngest-older-store search: age is distance from the STQ head, so wrap is free.
    always_comb begin
        ld_addr  = ldq_address[load_fired_ldq_index];
        ld_mask  = byte_mask(ldq_size[load_fired_ldq_index], ld_addr[OFFW-1:0]);
        st_mask  = '0;
        age      = '0;
        found    = 1'b0;
        best_idx = '0;
        best_age = '0;
        for (int i = 0; i < STQ_SIZE; i++) begin
            st_mask = byte_mask(stq_size[i], stq_address[i][OFFW-1:0]);
            age     = SQW'(i) - stq_head;
            if (ldq_store_mask[load_fired_ldq_index][i] && stq_valid[i] && stq_address_valid[i] &&
                stq_address[i][XLEN-1:OFFW] == ld_addr[XLEN-1:OFFW] && |(st_mask & ld_mask) &&
                (!found || age > best_age)) begin
                found    = 1'b1;
                best_idx = SQW'(i);
                best_age = age;
            end
        end
        best_mask = byte_mask(stq_size[best_idx], stq_address[best_idx][OFFW-1:0]);
        covers    = (best_mask & ld_mask) == ld_mask;
        can_fwd   = found && covers && stq_data_valid[best_idx];
        insert    = load_fired && found && !can_fwd;
    end

    // Lowest ready entry wins; loop runs downward so the last hit is the lowest index.
    always_comb begin
        wake_hit = 1'b0;
        wake_sel = '0;
        for (int e = LDQ_SIZE - 1; e >= 0; e--) begin
            if (sleeping[e] && (tbl_commit[e] ? !stq_valid[tbl_idx[e]]
                                              : (stq_data_valid[tbl_idx[e]] || !stq_valid[tbl_idx[e]]))) begin
                wake_hit = 1'b1;
                wake_sel = LQW'(e);
            end
        end
        wake_go = wake_hit && !(insert && wake_sel == load_fired_ldq_index);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            kill_mem_req       <= 1'b0;
            forward            <= 1'b0;
            stq_forward_index  <= '0;
            forward_byte_shift <= '0;
            sleep              <= 1'b0;
            sleep_rob_tag      <= '0;
            sleeping           <= '0;
            tbl_idx            <= '0;
            tbl_commit         <= '0;
            wake_valid         <= 1'b0;
            wake_ldq_index     <= '0;
        end else if (flush) begin
            kill_mem_req       <= 1'b0;
            forward            <= 1'b0;
            stq_forward_index  <= '0;
            forward_byte_shift <= '0;
            sleep              <= 1'b0;
            sleep_rob_tag      <= '0;
            sleeping           <= '0;
            tbl_idx            <= '0;
            tbl_commit         <= '0;
            wake_valid         <= 1'b0;
            wake_ldq_index     <= '0;
        end else begin
            kill_mem_req       <= load_fired && found;
            forward            <= load_fired && can_fwd;
            stq_forward_index  <= (load_fired && can_fwd) ? best_idx : '0;
            forward_byte_shift <= (load_fired && can_fwd) ?
                                  ld_addr[OFFW-1:0] - stq_address[best_idx][OFFW-1:0] : '0;
            sleep              <= insert;
            sleep_rob_tag      <= insert ? stq_rob_tag[best_idx] : '0;
            wake_valid         <= wake_go;
            wake_ldq_index     <= wake_go ? wake_sel : '0;
            if (wake_go) sleeping[wake_sel] <= 1'b0;
            // Insert after the clear so a same-index insert overwrites the entry.
            if (insert) begin
                sleeping[load_fired_ldq_index]   <= 1'b1;
                tbl_idx[load_fired_ldq_index]    <= best_idx;
                tbl_commit[load_fired_ldq_index] <= !covers;
            end
        end
    end

endmodule
`default_nettype wire
